// File: rtl/accel_conv_core_pkg.sv
// accel_conv_core_pkg: shared routes, CTRL offsets, status bits, FSM states and element type
package accel_conv_core_pkg;
    localparam int ACCL_DATA_W = 32;
    localparam int K_W = 4;
    typedef logic signed [ACCL_DATA_W-1:0] accl_data_t;
    typedef enum logic [1:0] {ROUTE_CTRL, ROUTE_COEFF, ROUTE_PIXEL, ROUTE_RESULT} route_e;
    localparam logic [3:0] CTRL_SOFT_RST = 4'd0;
    localparam logic [3:0] CTRL_START    = 4'd1;
    localparam logic [3:0] CTRL_STATUS   = 4'd2;
    localparam logic [3:0] CTRL_CLEAR    = 4'd3;
    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_ERR  = 3;
    localparam int ST_RELU = 4;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/accel_conv_core_mac_seq.sv
// accel_mac_seq: sequential signed MAC over NUM_COEFFS operand pairs fetched by index
// Ports: clk/rst, abort (soft clear), start, coeff/pix operands for index idx,
//        busy, done (one-cycle pulse in DONE), result (full accumulator width).
// Macro ACCL_RELU_EN: clamp a negative accumulator to zero when storing result.
module accel_mac_seq
    import accel_conv_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_COEFFS = 9
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         abort,
    input  logic                         start,
    input  logic signed [DATA_W-1:0]     coeff,
    input  logic signed [DATA_W-1:0]     pix,
    output logic [K_W-1:0]               idx,
    output logic                         busy,
    output logic                         done,
    output logic signed [2*DATA_W+3:0]   result
);
    localparam int ACC_W = 2*DATA_W+4;
    state_e state, stateNext;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*DATA_W-1:0] prod;
    logic lastK;
    assign prod  = (2*DATA_W)'(coeff) * (2*DATA_W)'(pix);
    assign lastK = idx == K_W'(NUM_COEFFS-1);
    assign busy  = state != S_IDLE;
    assign done  = state == S_DONE;
    always_ff @(posedge clk) begin
        if (rst || abort) state <= S_IDLE;
        else state <= stateNext;
    end
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  stateNext = start ? S_RUN : S_IDLE;
            S_RUN:   stateNext = lastK ? S_DONE : S_RUN;
            default: stateNext = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            idx    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                idx <= '0;
                acc <= '0;
            end
            if (state == S_RUN) begin
                acc <= acc + {{4{prod[2*DATA_W-1]}}, prod};
                idx <= lastK ? idx : idx + 1'b1;
            end
`ifdef ACCL_RELU_EN
            if (state == S_DONE) result <= acc[ACC_W-1] ? '0 : acc;
`else
            if (state == S_DONE) result <= acc;
`endif
        end
    end
endmodule

// File: rtl/accel_conv_core.sv
// accel_conv_core: bus-mapped coefficient/pixel buffers feeding a sequential signed MAC
// Ports: clk, rst (sync, active-high); wr_en_i/rd_en_i/addr_i/wdata_i register bus;
//        rdata_o/rdata_valid_o registered read return; irq_o = sticky done.
// Macro ACCL_RELU_EN: negative results stored as 0; status bit 4 reports it.
module accel_conv_core
    import accel_conv_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int ROUTE_BITS = 2,
    parameter int NUM_COEFFS = 9,
    parameter int PX_CH      = 8,
    parameter int PX_DEPTH   = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              irq_o
);
    localparam int TOTAL = PX_CH*PX_DEPTH;
    localparam int CNT_W = $clog2(TOTAL)+1;
    localparam int CH_W  = PX_CH > 1 ? $clog2(PX_CH) : 1;
    localparam int DP_W  = PX_DEPTH > 1 ? $clog2(PX_DEPTH) : 1;
    localparam int ACC_W = 2*DATA_W+4;
    localparam logic [4:0] NC = 5'(NUM_COEFFS);
`ifdef ACCL_RELU_EN
    localparam logic RELU_ON = 1'b1;
`else
    localparam logic RELU_ON = 1'b0;
`endif
    route_e route;
    logic [3:0] off;
    logic unusedAddr;
    logic signed [DATA_W-1:0] coeff [NUM_COEFFS];
    logic signed [DATA_W-1:0] pix [PX_CH][PX_DEPTH];
    logic [CNT_W-1:0] wrCnt, kIdx;
    logic [K_W-1:0] macIdx;
    logic signed [DATA_W-1:0] macCoeff, macPix;
    logic signed [ACC_W-1:0] result;
    logic wrCtrl, softRst, startCmd, clrSticky, coeffWr, pixWr, full;
    logic busy, macDone, doneFlag, ovf, err;
    logic [4:0] status;
    logic [DATA_W-1:0] rdMux;
    assign route      = route_e'(addr_i[ADDR_W-1 -: ROUTE_BITS]);
    assign off        = addr_i[3:0];
    assign unusedAddr = ^addr_i[ADDR_W-ROUTE_BITS-1:4];
    assign wrCtrl     = wr_en_i && route == ROUTE_CTRL;
    assign softRst    = wrCtrl && off == CTRL_SOFT_RST;
    assign startCmd   = wrCtrl && off == CTRL_START && wdata_i[0];
    assign clrSticky  = wrCtrl && off == CTRL_CLEAR;
    assign coeffWr    = wr_en_i && route == ROUTE_COEFF;
    assign pixWr      = wr_en_i && route == ROUTE_PIXEL;
    assign full       = wrCnt == CNT_W'(TOTAL);
    assign irq_o      = doneFlag;
    // flat index k lives at channel k%PX_CH, slot k/PX_CH, same as the write order
    assign kIdx     = CNT_W'(macIdx);
    assign macCoeff = coeff[macIdx];
    assign macPix   = pix[CH_W'(kIdx % CNT_W'(PX_CH))][DP_W'(kIdx / CNT_W'(PX_CH))];
    accel_mac_seq #(.DATA_W(DATA_W), .NUM_COEFFS(NUM_COEFFS)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .abort  (softRst),
        .start  (startCmd),
        .coeff  (macCoeff),
        .pix    (macPix),
        .idx    (macIdx),
        .busy   (busy),
        .done   (macDone),
        .result (result)
    );
    always_ff @(posedge clk) begin
        if (rst || softRst) begin
            coeff    <= '{default: '0};
            pix      <= '{default: '0};
            wrCnt    <= '0;
            doneFlag <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (clrSticky) begin
                doneFlag <= 1'b0;
                ovf      <= 1'b0;
                err      <= 1'b0;
            end
            if (macDone) doneFlag <= 1'b1;
            if ((coeffWr || pixWr) && busy) err <= 1'b1;
            if (coeffWr && !busy && {1'b0, off} < NC) coeff[off] <= wdata_i;
            if (pixWr && !busy && full) ovf <= 1'b1;
            if (pixWr && !busy && !full) begin
                pix[CH_W'(wrCnt % CNT_W'(PX_CH))][DP_W'(wrCnt / CNT_W'(PX_CH))] <= wdata_i;
                wrCnt <= wrCnt + 1'b1;
            end
        end
    end
    always_comb begin
        status          = '0;
        status[ST_DONE] = doneFlag;
        status[ST_BUSY] = busy;
        status[ST_OVF]  = ovf;
        status[ST_ERR]  = err;
        status[ST_RELU] = RELU_ON;
    end
    always_comb begin
        rdMux = '0;
        case (route)
            ROUTE_CTRL:   rdMux = off == CTRL_STATUS ? DATA_W'(status) : '0;
            ROUTE_COEFF:  rdMux = {1'b0, off} < NC ? coeff[off] : '0;
            ROUTE_PIXEL:  rdMux = '0;
            ROUTE_RESULT: rdMux = off == 4'd0 ? result[DATA_W-1:0] :
                                  off == 4'd1 ? result[2*DATA_W-1:DATA_W] :
                                  off == 4'd2 ? {{(DATA_W-4){result[ACC_W-1]}}, result[ACC_W-1 -: 4]} : '0;
        endcase
    end
    // rdata_o is deliberately left alone by the soft reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            rdata_valid_o <= rd_en_i;
            if (rd_en_i) rdata_o <= rdMux;
        end
    end
endmodule
